// File: rtl/intra4x4_pkg.sv
// Shared types, mode codes and pixel helpers for intra-4x4 mode decision.
// Blocks pack pixel (r,c) at bits [8*(4r+c)+7 : 8*(4r+c)].
package intra4x4_pkg;

  localparam logic [3:0] I4_VERT = 4'd0;
  localparam logic [3:0] I4_HOR  = 4'd1;
  localparam logic [3:0] I4_DC   = 4'd2;

  localparam logic [7:0] DC_DEFAULT = 8'd128;
  localparam int         SAD_W      = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] px(
    input logic [127:0] b,
    input logic [1:0]   r,
    input logic [1:0]   c
  );
    return b[{r, c, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] row_of(
    input logic [127:0] b,
    input logic [1:0]   r
  );
    return b[{r, 5'b00000} +: 32];
  endfunction

  function automatic logic [9:0] sum4(
    input logic [31:0] v
  );
    return 10'(v[7:0]) + 10'(v[15:8])
         + 10'(v[23:16]) + 10'(v[31:24]);
  endfunction

  function automatic logic [7:0] calc_dc(
    input logic [31:0] top,
    input logic [31:0] left,
    input logic        va,
    input logic        vb
  );
    logic [9:0] st;
    logic [9:0] sl;
    st = sum4(top);
    sl = sum4(left);
    if (va && vb)
      return 8'((11'(st) + 11'(sl) + 11'd4) >> 3);
    else if (vb)
      return 8'((st + 10'd2) >> 2);
    else if (va)
      return 8'((sl + 10'd2) >> 2);
    else
      return DC_DEFAULT;
  endfunction

  function automatic logic [3:0] first_mode(
    input logic va,
    input logic vb
  );
    if (vb)      return I4_VERT;
    else if (va) return I4_HOR;
    else         return I4_DC;
  endfunction

  function automatic logic [3:0] next_mode(
    input logic [3:0] m,
    input logic       va
  );
    if (m == I4_VERT && va) return I4_HOR;
    else                    return I4_DC;
  endfunction

  function automatic logic [31:0] pred_row(
    input logic [3:0]  m,
    input logic [31:0] top,
    input logic [31:0] left,
    input logic [7:0]  dc,
    input logic [1:0]  r
  );
    if (m == I4_VERT)     return top;
    else if (m == I4_HOR) return {4{left[{r, 3'b000} +: 8]}};
    else                  return {4{dc}};
  endfunction

  function automatic logic [127:0] pred_block(
    input logic [3:0]  m,
    input logic [31:0] top,
    input logic [31:0] left,
    input logic [7:0]  dc
  );
    logic [127:0] b;
    b = '0;
    for (int r = 0; r < 4; r++)
      b[32*r +: 32] = pred_row(m, top, left, dc, 2'(r));
    return b;
  endfunction

endpackage

// File: rtl/intra4x4_row_sad.sv
// Sum of absolute differences over one 4-pixel row.
// Purely combinational; worst case 4*255 = 1020 fits 10 bits.
module intra4x4_row_sad (
  input  logic [31:0] cur_row,
  input  logic [31:0] pred_row,
  output logic [9:0]  sad
);

  // Accumulate |cur - pred| per column
  always_comb begin
    logic [7:0] a;
    logic [7:0] b;
    sad = '0;
    for (int c = 0; c < 4; c++) begin
      a = cur_row[8*c +: 8];
      b = pred_row[8*c +: 8];
      sad = sad + 10'((a > b) ? (a - b) : (b - a));
    end
  end

endmodule

// File: rtl/intra4x4_mode_decision.sv
// Intra-4x4 mode decision over V/H/DC by row-serial SAD.
// One row per cycle, four cycles per available mode.
module intra4x4_mode_decision #(
  parameter int PIX_W = 8,
  parameter int SAD_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [16*PIX_W-1:0]  cur_blk,
  input  logic [4*PIX_W-1:0]   top_pix,
  input  logic [4*PIX_W-1:0]   left_pix,
  input  logic                 mbAddrA_valid,
  input  logic                 mbAddrB_valid,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           best_mode,
  output logic [SAD_W-1:0]     best_sad,
  output logic [16*PIX_W-1:0]  pred_blk
);

  import intra4x4_pkg::*;

  state_e             state_q, state_d;
  logic [127:0]       cur_q, cur_d;
  logic [31:0]        top_q, top_d;
  logic [31:0]        left_q, left_d;
  logic               va_q, va_d;
  logic               vb_q, vb_d;
  logic [7:0]         dc_q, dc_d;
  logic [3:0]         mode_q, mode_d;
  logic [1:0]         row_q, row_d;
  logic [SAD_W-1:0]   acc_q, acc_d;
  logic               first_q, first_d;
  logic [3:0]         bmode_q, bmode_d;
  logic [SAD_W-1:0]   bsad_q, bsad_d;
  logic               done_q, done_d;
  logic [3:0]         omode_q, omode_d;
  logic [SAD_W-1:0]   osad_q, osad_d;
  logic [127:0]       opred_q, opred_d;

  logic [9:0]         row_sad;
  logic [SAD_W-1:0]   acc_sum;

  intra4x4_row_sad u_row_sad (
    .cur_row  (row_of(cur_q, row_q)),
    .pred_row (pred_row(mode_q, top_q, left_q, dc_q, row_q)),
    .sad      (row_sad)
  );

  assign acc_sum   = acc_q + SAD_W'(row_sad);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign best_mode = omode_q;
  assign best_sad  = osad_q;
  assign pred_blk  = opred_q;

  // Capture, row-serial SAD accumulation, best tracking, result load
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    top_d   = top_q;
    left_d  = left_q;
    va_d    = va_q;
    vb_d    = vb_q;
    dc_d    = dc_q;
    mode_d  = mode_q;
    row_d   = row_q;
    acc_d   = acc_q;
    first_d = first_q;
    bmode_d = bmode_q;
    bsad_d  = bsad_q;
    done_d  = 1'b0;
    omode_d = omode_q;
    osad_d  = osad_q;
    opred_d = opred_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = cur_blk;
          top_d   = top_pix;
          left_d  = left_pix;
          va_d    = mbAddrA_valid;
          vb_d    = mbAddrB_valid;
          dc_d    = calc_dc(top_pix, left_pix,
                            mbAddrA_valid, mbAddrB_valid);
          mode_d  = first_mode(mbAddrA_valid, mbAddrB_valid);
          row_d   = 2'd0;
          acc_d   = '0;
          first_d = 1'b1;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        row_d = row_q + 2'd1;
        if (row_q == 2'd3) begin
          acc_d   = '0;
          first_d = 1'b0;
          if (first_q || acc_sum < bsad_q) begin
            bmode_d = mode_q;
            bsad_d  = acc_sum;
          end
          if (mode_q == I4_DC)
            state_d = S_DONE;
          else
            mode_d = next_mode(mode_q, va_q);
        end else begin
          acc_d = acc_sum;
        end
      end
      S_DONE: begin
        omode_d = bmode_q;
        osad_d  = bsad_q;
        opred_d = pred_block(bmode_q, top_q, left_q, dc_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      top_q   <= '0;
      left_q  <= '0;
      va_q    <= 1'b0;
      vb_q    <= 1'b0;
      dc_q    <= '0;
      mode_q  <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      first_q <= 1'b0;
      bmode_q <= '0;
      bsad_q  <= '0;
      done_q  <= 1'b0;
      omode_q <= '0;
      osad_q  <= '0;
      opred_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      top_q   <= top_d;
      left_q  <= left_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      dc_q    <= dc_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      first_q <= first_d;
      bmode_q <= bmode_d;
      bsad_q  <= bsad_d;
      done_q  <= done_d;
      omode_q <= omode_d;
      osad_q  <= osad_d;
      opred_q <= opred_d;
    end
  end

endmodule

// File: doc/intra4x4_mode_decision.md
Name: intra4x4_mode_decision

Overview:
- Downstream consumer of the intra-4x4 predictor-setup stage.
- Takes one 4x4 luma block, its 4 top and 4 left neighbour pixels, and the left/top availability flags.
- Evaluates the available modes among Vertical (0), Horizontal (1) and DC (2) by row-serial SAD.
- Returns the best mode, its SAD and the 4x4 prediction block, for the residual/transform and mode-coding stages.

Parameters:
- PIX_W, 8, bits per luma sample.
- SAD_W, 12, SAD accumulator width; 16*255 = 4080 fits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- cur_blk  in  128  current 4x4 block; pixel (r,c) at bits [8*(4r+c)+7 : 8*(4r+c)].
- top_pix  in  32  top neighbours; column c at [8c+7:8c].
- left_pix  in  32  left neighbours; row r at [8r+7:8r].
- mbAddrA_valid  in  1  left neighbours available.
- mbAddrB_valid  in  1  top neighbours available.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid.
- best_mode  out  4  chosen intra4x4 mode: 0 = V, 1 = H, 2 = DC.
- best_sad  out  12  SAD of the chosen mode.
- pred_blk  out  128  prediction for best_mode; same packing as cur_blk.

Behaviour:
- Reset: state IDLE; busy = 0, done = 0, best_mode = 0, best_sad = 0, pred_blk = 0; all internal registers cleared.
- rst dominates: asserting it mid-operation aborts to IDLE next edge, no done pulse.
- Input capture: on the edge where state == IDLE and start == 1, register cur_blk, top_pix, left_pix and both valids. Inputs are don't-care afterwards.
- start while busy or in DONE: ignored; no queuing.
- Mode list, fixed order:
  - V if mbAddrB_valid.
  - H if mbAddrA_valid.
  - DC always.
  - N = 1..3 modes.
- DC value dc, 8 bits:
  - both available: (sum top + sum left + 4) >> 3.
  - top only: (sum top + 2) >> 2.
  - left only: (sum left + 2) >> 2.
  - neither: 128.
  - dc is computed in the capture cycle and registered.
- Predictions:
  - V: pred(r,c) = top[c].
  - H: pred(r,c) = left[r].
  - DC: pred(r,c) = dc.
- FSM: IDLE -> EVAL -> DONE -> IDLE.
- EVAL:
  - One row per cycle: row_sad = sum over c of |cur(r,c) - pred(r,c)|, unsigned, 10 bits.
  - Accumulate into acc (SAD_W bits); 4 cycles per mode.
  - After row 3: compare acc with the running best.
  - Update the best only if acc < best (strict). Ties therefore keep the lower mode number.
  - The first evaluated mode always loads the best.
  - Clear acc and advance to the next listed mode; after the last mode, go to DONE.
- DONE (one cycle): register best_mode, best_sad, pred_blk (built from the latched neighbours/dc and best_mode). Assert done; next state IDLE.
- Latency: done is high for exactly 1 cycle, 4N+1 clocks after the edge that sampled start (N=1: 5; N=3: 13). busy falls in the same cycle done rises.
- Outputs hold their values until the next done or reset.
- A new start may be accepted in the cycle after done (IDLE).

Decomposition:
- Package intra4x4_pkg:
  - Mode constants I4_VERT = 4'd0, I4_HOR = 4'd1, I4_DC = 4'd2.
  - DC_DEFAULT = 8'd128; SAD_W.
  - FSM state enum (IDLE, EVAL, DONE).
  - Pixel pack/unpack helper functions.
- One sub-module, intra4x4_row_sad: combinational, four 8-bit current pixels and four predicted pixels in, 10-bit row SAD out. Instantiated once.

Test Plan:
- Both available, cur = top replicated in every row, left all 0, top = {10,20,30,40} -> best_mode = 0, best_sad = 0, done 13 cycles after start, pred_blk rows = {10,20,30,40}.
- Both available, cur all 50, top all 50, left all 50 -> V, H and DC all SAD 0; tie gives best_mode = 0, best_sad = 0.
- Neither available, cur all 100 -> only DC, dc = 128, best_mode = 2, best_sad = 16*28 = 448, done 5 cycles after start.
- Left only, left = {1,2,3,4}, cur row r all = left[r] -> best_mode = 1, best_sad = 0, done 9 cycles after start; also check dc = (10+2)>>2 = 3.
- Top only, top = {255,255,255,255}, cur all 0 -> V SAD 4080, DC (dc = 255) SAD 4080; tie gives best_mode = 0, best_sad = 4080 (no overflow).
- start pulsed while busy, then rst asserted mid-EVAL -> second start ignored; after rst no done, all outputs 0; next start completes normally.
